// File: rtl/axis_string_pkg.sv
// Shared definitions for the string arbiter: FSM states, default
// message terminator and the width of the destination index.
package axis_string_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } state_t;

  localparam logic [7:0]  DEFAULT_TERMINATION = 8'h0A;
  localparam int unsigned TDEST_W             = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selection: first asserted request found by
// scanning upward from last+1, wrapping modulo CHANNELS.
module rr_pick
  import axis_string_pkg::*;
#(
  parameter int unsigned CHANNELS = 4
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [TDEST_W-1:0]  last,
  output logic [TDEST_W-1:0]  grant,
  output logic                any
);

  // Offsets are visited in priority order; a constant channel index is
  // matched against each offset so every select stays a fixed bit.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      for (int unsigned j = 0; j < CHANNELS; j++) begin
        if (!any && req[j] && (((32'(last) + i) % CHANNELS) == j)) begin
          grant = TDEST_W'(j);
          any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axis_string_arbiter.sv
// Multi-channel byte-stream arbiter: grants one requester at a time in
// round-robin order and holds the grant until a terminator byte or the
// per-grant length limit has been transferred.
module axis_string_arbiter
  import axis_string_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter logic [7:0]  TERMINATION = DEFAULT_TERMINATION,
  parameter int unsigned MAX_LEN     = 256
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic [CHANNELS*8-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]   s_axis_tvalid,
  output logic [CHANNELS-1:0]   s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [TDEST_W-1:0]    m_axis_tdest
);

  localparam int unsigned      CNT_W    = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);

  state_t             state;
  logic [TDEST_W-1:0] grant;
  logic [TDEST_W-1:0] last_grant;
  logic [TDEST_W-1:0] pick;
  logic               pick_any;
  logic [CNT_W-1:0]   count;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               hs;

  rr_pick #(
    .CHANNELS(CHANNELS)
  ) u_rr_pick (
    .req  (s_axis_tvalid),
    .last (last_grant),
    .grant(pick),
    .any  (pick_any)
  );

  // Route the granted channel through; outside PASS everything stays quiet
  always_comb begin
    sel_data      = '0;
    sel_valid     = 1'b0;
    s_axis_tready = '0;
    if (state == PASS) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (grant == TDEST_W'(c)) begin
          sel_data         = s_axis_tdata[c*8 +: 8];
          sel_valid        = s_axis_tvalid[c];
          s_axis_tready[c] = m_axis_tready;
        end
      end
    end
  end

  assign m_axis_tdata  = sel_data;
  assign m_axis_tvalid = sel_valid;
  assign m_axis_tdest  = grant;
  assign m_axis_tlast  = (state == PASS) &&
                         ((sel_data == TERMINATION) || (count == CNT_LAST));
  assign hs            = sel_valid & m_axis_tready;

  // Arbitration FSM: one bubble cycle in IDLE to register the pick, then
  // pass bytes until a handshake carries tlast
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= TDEST_W'(CHANNELS - 1);
      count      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick;
            count <= '0;
            state <= PASS;
          end
        end
        PASS: begin
          if (hs) begin
            if (m_axis_tlast) begin
              last_grant <= grant;
              state      <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_string_arbiter.sv
// Bench for axis_string_arbiter (4 channels, 4-byte grant limit).
module tb_axis_string_arbiter;

  localparam int unsigned CH = 4;
  localparam int unsigned ML = 4;

  logic            aclk = 1'b0;
  logic            arstn;
  logic [CH*8-1:0] s_tdata;
  logic [CH-1:0]   s_tvalid;
  logic [CH-1:0]   s_tready;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [3:0]      m_tdest;

  always #5 aclk = ~aclk;

  axis_string_arbiter #(
    .CHANNELS(CH),
    .MAX_LEN (ML)
  ) dut (
    .aclk         (aclk),
    .arstn        (arstn),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tdest (m_tdest)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] dest;
    logic       last;
    int         stamp;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] dest;
    logic       last;
    int         gap;
  } exp_t;

  logic [7:0] src_q[CH][$];
  rec_t       out_q[$];
  logic [CH-1:0] hold;
  logic [CH-1:0] pend;
  bit         rand_valid;
  bit         rand_ready;
  int         checks;
  int         failures;
  int         cyc = 0;
  int         burst_len;
  logic [3:0] cur_dest;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Message-level model: bytes of a grant come from one channel in source
  // order, and a grant ends on a terminator or on its ML-th byte.
  initial begin
    logic exp_last;
    burst_len = 0;
    cur_dest  = '0;
    pend      = '0;
    forever begin
      @(negedge aclk);
      if (!arstn) begin
        burst_len = 0;
        pend      = '0;
      end else begin
        chk("ready_onehot0", 32'($countones(s_tready) <= 1), 1);
        if (m_tvalid) begin
          chk("tdest_range", 32'(m_tdest < CH), 1);
          if (m_tdest < CH) begin
            chk("src_valid", s_tvalid[m_tdest], 1);
            chk("ready_mirror", 32'(s_tready), m_tready ? (32'd1 << m_tdest) : 32'd0);
            if (src_q[m_tdest].size() == 0) chk("data_src_nonempty", 0, 1);
            else chk("data", m_tdata, src_q[m_tdest][0]);
          end
          exp_last = (m_tdata == 8'h0A) || (burst_len == ML - 1);
          chk("tlast", m_tlast, exp_last);
          if (burst_len > 0) chk("grant_hold", m_tdest, cur_dest);
          if (m_tready) begin
            out_q.push_back('{data: m_tdata, dest: m_tdest, last: m_tlast, stamp: cyc + 1});
            cur_dest  = m_tdest;
            burst_len = exp_last ? 0 : burst_len + 1;
          end
        end
        for (int c = 0; c < CH; c++) pend[c] = s_tvalid[c] & s_tready[c];
      end
    end
  end

  // Source/sink driver: retire accepted bytes, present queue heads
  initial begin
    s_tvalid = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      for (int c = 0; c < CH; c++)
        if (pend[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
      pend = '0;
      for (int c = 0; c < CH; c++) begin
        if (src_q[c].size() > 0) begin
          s_tdata[c*8 +: 8] = src_q[c][0];
          s_tvalid[c] = !hold[c] && (!rand_valid || ($urandom_range(3) != 0));
        end else begin
          s_tdata[c*8 +: 8] = 8'h00;
          s_tvalid[c] = 1'b0;
        end
      end
      m_tready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic load(input int c, input string s);
    for (int i = 0; i < s.len(); i++) src_q[c].push_back(s[i]);
  endtask

  task automatic wait_out(input int n, input int budget, input string name);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(out_q.size() >= n), 1);
  endtask

  task automatic do_reset();
    arstn      = 1'b0;
    hold       = '0;
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    for (int c = 0; c < CH; c++) src_q[c].delete();
    pend = '0;
    tick();
    tick();
    out_q.delete();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_s_tready"}, 32'(s_tready), 0);
    chk({name, "_m_tvalid"}, m_tvalid, 0);
    chk({name, "_m_tlast"}, m_tlast, 0);
    chk({name, "_m_tdest"}, m_tdest, 0);
    chk({name, "_m_tdata"}, m_tdata, 0);
  endtask

  task automatic cmp_table(input string name, input exp_t tbl[$]);
    chk({name, "_count"}, out_q.size(), tbl.size());
    for (int i = 0; i < tbl.size() && i < out_q.size(); i++) begin
      chk($sformatf("%s_data%0d", name, i), out_q[i].data, tbl[i].data);
      chk($sformatf("%s_dest%0d", name, i), out_q[i].dest, tbl[i].dest);
      chk($sformatf("%s_last%0d", name, i), out_q[i].last, tbl[i].last);
      if (i > 0 && tbl[i].gap != 0)
        chk($sformatf("%s_gap%0d", name, i), out_q[i].stamp - out_q[i-1].stamp, tbl[i].gap);
    end
    out_q.delete();
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    exp_t t31[$], t32[$], t33[$], t34[$], t35[$], t36[$];
    int   total;
    int   per_ch[CH];
    int   got_ch[CH];
    string msg;

    t31 = '{'{8'h41, 0, 0, 0}, '{8'h42, 0, 0, 1}, '{8'h0A, 0, 1, 1},
            '{8'h43, 2, 0, 2}, '{8'h0A, 2, 1, 1}};
    t32 = '{'{8'h58, 0, 0, 0}, '{8'h0A, 0, 1, 1}, '{8'h58, 1, 0, 2}, '{8'h0A, 1, 1, 1},
            '{8'h58, 2, 0, 2}, '{8'h0A, 2, 1, 1}, '{8'h58, 3, 0, 2}, '{8'h0A, 3, 1, 1},
            '{8'h58, 0, 0, 2}, '{8'h0A, 0, 1, 1}};
    t33 = '{'{8'h61, 1, 0, 0}, '{8'h62, 1, 0, 1}, '{8'h63, 1, 0, 1}, '{8'h64, 1, 1, 1},
            '{8'h65, 1, 0, 2}, '{8'h66, 1, 0, 1}, '{8'h0A, 1, 1, 1}};
    t34 = '{'{8'h48, 3, 0, 0}, '{8'h65, 3, 0, 0}, '{8'h6C, 3, 0, 0}, '{8'h6C, 3, 1, 0},
            '{8'h6F, 3, 0, 0}, '{8'h0A, 3, 1, 0}};
    t35 = '{'{8'h70, 1, 0, 0}, '{8'h71, 1, 0, 1},
            '{8'h30, 0, 0, 0}, '{8'h0A, 0, 1, 1}, '{8'h31, 1, 0, 2}, '{8'h0A, 1, 1, 1}};
    t36 = '{'{8'h61, 0, 0, 0}, '{8'h62, 0, 0, 0}, '{8'h0A, 0, 1, 1},
            '{8'h7A, 1, 0, 2}, '{8'h0A, 1, 1, 1}};

    checks     = 0;
    failures   = 0;
    hold       = '0;
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    arstn      = 1'b0;

    // reset state with requests already pending, then simultaneous ch0/ch2
    tick();
    load(0, "AB\n");
    load(2, "C\n");
    tick();
    tick();
    chk("reset_requests_seen", 32'(s_tvalid), 32'b0101);
    check_zero("reset");
    arstn = 1'b1;
    #1;
    chk("release_ready", 32'(s_tready), 0);
    wait_out(5, 50, "t31_wait");
    tick();
    tick();
    cmp_table("t31", t31);

    // all channels continuously valid
    do_reset();
    load(0, "X\nX\n");
    for (int c = 1; c < CH; c++) load(c, "X\n");
    tick();
    arstn = 1'b1;
    wait_out(10, 100, "t32_wait");
    tick();
    cmp_table("t32", t32);

    // grant length limit and re-grant of a sole requester
    do_reset();
    load(1, "abcdef\n");
    tick();
    arstn = 1'b1;
    wait_out(7, 100, "t33_wait");
    tick();
    cmp_table("t33", t33);

    // random downstream back-pressure
    do_reset();
    rand_ready = 1'b1;
    load(3, "Hello\n");
    tick();
    arstn = 1'b1;
    wait_out(6, 300, "t34_wait");
    rand_ready = 1'b0;
    tick();
    cmp_table("t34", t34);

    // reset mid-message
    do_reset();
    load(1, "pqrs\n");
    tick();
    arstn = 1'b1;
    wait_out(2, 50, "t35_wait_pre");
    @(posedge aclk);
    #2;
    arstn = 1'b0;
    for (int c = 0; c < CH; c++) src_q[c].delete();
    pend = '0;
    #1;
    check_zero("midreset");
    tick();
    load(0, "0\n");
    load(1, "1\n");
    tick();
    tick();
    arstn = 1'b1;
    wait_out(6, 50, "t35_wait_post");
    tick();
    cmp_table("t35", t35);

    // granted channel stalls while another requests
    do_reset();
    load(0, "ab\n");
    tick();
    arstn = 1'b1;
    wait_out(1, 50, "t36_wait_first");
    hold[0] = 1'b1;
    load(1, "z\n");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_ch1_ready", s_tready[1], 0);
      chk("stall_no_valid", m_tvalid, 0);
    end
    hold[0] = 1'b0;
    wait_out(5, 50, "t36_wait");
    tick();
    cmp_table("t36", t36);

    // randomized traffic against the message-level model
    do_reset();
    rand_valid = 1'b1;
    rand_ready = 1'b1;
    total = 0;
    for (int c = 0; c < CH; c++) begin
      per_ch[c] = 0;
      got_ch[c] = 0;
      for (int m = 0; m < 3; m++) begin
        int len;
        len = int'($urandom_range(7, 1));
        msg = "";
        for (int b = 0; b < len; b++) msg = {msg, string'(8'($urandom_range(8'h7E, 8'h20)))};
        msg = {msg, "\n"};
        load(c, msg);
        per_ch[c] += msg.len();
        total     += msg.len();
      end
    end
    tick();
    arstn = 1'b1;
    wait_out(total, 4000, "rand_wait");
    tick();
    tick();
    chk("rand_total", out_q.size(), total);
    foreach (out_q[i]) if (out_q[i].dest < CH) got_ch[out_q[i].dest]++;
    for (int c = 0; c < CH; c++) chk($sformatf("rand_ch%0d_bytes", c), got_ch[c], per_ch[c]);
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    out_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
